rx_buffer: RTL
==============

RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 8: buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 req  input  1  upstream master request; data is valid while high.
REQ-006 data  input  DW  upstream write data.
REQ-007 gnt  output  1  grant to upstream master; high means a word can be accepted.
REQ-008 out_valid  output  1  downstream word available.
REQ-009 out_data  output  DW  downstream word; head of buffer.
REQ-010 out_ready  input  1  downstream consumer accepts the word.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 stall_cnt  output  8  saturating count of cycles where req=1 and gnt=0.

Function
REQ-013 gnt shall equal (count != DEPTH), driven combinationally from registered state only; it shall not depend on req in the same cycle.
REQ-014 A push shall occur at a posedge where req=1 and gnt=1; data is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-015 out_valid shall equal (count != 0); out_data shall equal mem[rd_ptr]; both are combinational from registered state.
REQ-016 A pop shall occur at a posedge where out_valid=1 and out_ready=1; rd_ptr increments modulo DEPTH.
REQ-017 Latency shall be one cycle: a word pushed at edge N is visible on out_data/out_valid after edge N; there is no same-cycle bypass.
REQ-018 Simultaneous push and pop shall leave count unchanged; both pointers advance.
REQ-019 When full, gnt shall be 0, req shall be ignored, and no data shall be written or lost.
REQ-020 A pop while full shall raise gnt in the following cycle; no push shall occur in that same edge.
REQ-021 When empty, out_valid shall be 0 and out_ready shall be ignored; out_data is don't-care.
REQ-022 Pointer wrap-around from DEPTH-1 to 0 shall be seamless; order is strictly FIFO.
REQ-023 stall_cnt shall increment on each posedge with req=1 and gnt=0, saturate at 255, and clear only on reset.
REQ-024 count shall never exceed DEPTH nor underflow below 0.

Reset
REQ-025 While rst=0: wr_ptr=0, rd_ptr=0, count=0, stall_cnt=0; hence gnt=1 and out_valid=0.
REQ-026 Assertion mid-transfer shall discard all buffered words immediately; memory contents need not be cleared.
REQ-027 The first push after deassertion shall be accepted at the first posedge with rst=1 and req=1.

Structure
REQ-028 A shared package rx_pkg shall hold DW_DEF=8, DEPTH_DEF=8, and typedef data_t (logic [DW_DEF-1:0]).
REQ-029 Storage, pointers, and count shall live in one module; no sub-module is required.
REQ-030 The upstream ports shall be connectable to the existing intf slave modport signals req, data, and gnt, unchanged.

Verification
REQ-031 Reset, then push 0x11, 0x22, 0x33 with out_ready=0 -> count=3, gnt=1, out_data=0x11.
REQ-032 Hold req=1 for 10 cycles with out_ready=0, DEPTH=8 -> 8 words accepted, gnt=0 from the cycle after the 8th push, stall_cnt=2.
REQ-033 From full, pulse out_ready for 1 cycle while req=1 -> first word popped, count=7, gnt=1 next cycle, 9th word accepted the cycle after, count=8.
REQ-034 Continuous req=1 and out_ready=1 for 20 cycles with incrementing data 0..19 -> output sequence is 0..19 in order, count stays at or below 1, pointers wrap twice.
REQ-035 Assert rst with count=5 -> count=0, out_valid=0, and gnt=1 immediately (asynchronous); after release, push 0xA5 -> out_data=0xA5.
REQ-036 Hold req=1 with out_ready=0 for 300 cycles -> stall_cnt saturates at 255.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared defaults and types for the receive buffer.
package rx_pkg;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;

   typedef logic [DW_DEF-1:0] data_t;
endpackage

// File: rtl/rx_buffer_if.sv
// Upstream request/grant handshake carried into the receive buffer.
interface rx_buffer_if #(parameter int DW = rx_pkg::DW_DEF);
   logic          req;
   logic [DW-1:0] data;
   logic          gnt;

   modport master (output req, output data, input  gnt);
   modport slave  (input  req, input  data, output gnt);
endinterface

// File: rtl/rx_buffer.sv
// Single-clock FIFO receive buffer: request/grant upstream, valid/ready downstream,
// plus a saturating count of cycles the upstream spent waiting for grant.
module rx_buffer
   import rx_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   rx_buffer_if.slave                 up,
   output logic                       out_valid,
   output logic [DW-1:0]              out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic [7:0]                 stall_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_stall_cnt;

   logic w_full;
   logic w_push;
   logic w_pop;
   logic w_stall;

   // Grant and valid come only from registered occupancy, never from req/ready.
   assign w_full    = (r_count == CW'(DEPTH));
   assign up.gnt    = ~w_full;
   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];

   assign w_push  = up.req & ~w_full;
   assign w_pop   = out_valid & out_ready;
   assign w_stall = up.req & w_full;

   assign count     = r_count;
   assign stall_cnt = r_stall_cnt;

   // Storage is not reset; reset only discards it by clearing occupancy.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= up.data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_stall && r_stall_cnt != 8'hFF) r_stall_cnt <= r_stall_cnt + 8'd1;
      end
   end
endmodule
